ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single 32K x 16 RAM port between the core (via address decode, RAM region 0x00) and the display reader.
//  Display has fixed priority with burst lock; core is protected by a starvation counter.
//  Routes synchronous read data back to the owning requester with a per-read valid strobe.
//  Sits between the core/display masters and the RAM, replacing direct core->RAM wiring.
// PARAMETERS
//  BURST_LEN  8   consecutive display grants locked once a display burst starts (1..255)
//  MAX_WAIT   4   cycles core may wait before it is forced onto the port (1..15)
//  RD_LAT     1   RAM read latency in cycles (1 or 2)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  core_req     in   1   core access request (already address-decoded to RAM region)
//  core_we      in   1   core write enable, qualified by core_req
//  core_addr    in   15  core word address
//  core_wdata   in   16  core write data
//  core_gnt     out  1   access accepted this cycle (combinational)
//  core_rvalid  out  1   core_rdata valid (RD_LAT cycles after a granted read)
//  core_rdata   out  16  read data to core
//  vid_req      in   1   display read request
//  vid_addr     in   15  display word address
//  vid_gnt      out  1   display access accepted this cycle (combinational)
//  vid_rvalid   out  1   vid_rdata valid
//  vid_rdata    out  16  read data to display
//  ram_addr     out  15  RAM address
//  ram_we       out  1   RAM write enable
//  ram_wdata    out  16  RAM write data
//  ram_rdata    in   16  RAM read data, RD_LAT cycles after address
// BEHAVIOUR
//  Arbitration (combinational each cycle, evaluated in this order):
//   - starve==1 and core_req: core wins.
//   - else vid_req: display wins.
//   - else core_req: core wins.  - else none: ram_we=0, ram_addr/ram_wdata hold last winner values.
//  Winner's addr/we/wdata drive the RAM; display never writes (ram_we=0 on display grant).
//  Exactly one of core_gnt/vid_gnt may be high; both 0 when no request.
//  Starvation counter wait_cnt[3:0]: +1 each cycle core_req && !core_gnt, saturating;
//   cleared on core_gnt or !core_req. starve = (wait_cnt >= MAX_WAIT), a registered flag.
//  Burst lock burst_cnt[7:0]: on display grant with burst_cnt==0, load BURST_LEN-1;
//   decrement on each further display grant. While burst_cnt!=0 a core request does
//   not win unless starve==1; a forced core grant pauses burst_cnt (no reload, no clear).
//   Dropping vid_req clears burst_cnt next cycle.
//  Read return: tag pipe of RD_LAT stages carries {valid, owner}; a stage is loaded on
//   every granted read (core_gnt && !core_we, or vid_gnt). At stage end the owner's
//   rvalid pulses 1 cycle; core_rdata/vid_rdata = ram_rdata (combinational pass-through).
//   Granted writes generate no rvalid. Back-to-back reads give one rvalid per cycle, in order.
//  Reset values: wait_cnt=0, starve=0, burst_cnt=0, tag pipe all invalid, so
//   core_rvalid=vid_rvalid=0, ram_we=0, ram_addr=0, ram_wdata=0 (last-winner hold regs).
//  Reset mid-operation: in-flight reads are dropped, no rvalid after reset.
//   Requesters reissue.
//  Reset has priority over all requests in the same cycle; no grants while reset=1.
//  Simultaneous: core and display requesting with starve=0 -> display; wait_cnt counts.
// STRUCTURE
//  Include file ram_arb_defs.vh: OWNER_CORE=1'b0, OWNER_VID=1'b1, RAM_AW=15, RAM_DW=16.
//  Sub-module rd_tag_pipe (parameter RD_LAT): shift register of {valid, owner}, sync reset.
//  Top holds arbitration logic, wait_cnt, burst_cnt and the RAM mux; ~200 lines total.
// TESTING
//  Core only: write 0x1234 @0x0005 then read @0x0005 -> core_gnt both cycles, rvalid 1 cycle after read, rdata 0x1234.
//  Display only, 10 reads @0x0100.. -> vid_gnt every cycle, 10 vid_rvalid in order, burst_cnt reloads after 8.
//  Both held high, MAX_WAIT=4 -> display 4 cycles, core granted 5th cycle, burst resumes at paused count.
//  Core read granted, reset asserted next cycle -> no core_rvalid. All outputs at reset values.
//  Alternating core write/display read each cycle with no starve -> display wins; write lands within MAX_WAIT+1 cycles.
//  RD_LAT=2 build: back-to-back core reads @0,1 -> rvalid in cycles 2 and 3 with matching data.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter: bus widths and the
// read-return tag carried through the latency pipe.
package ram_port_arbiter_pkg;

   localparam int unsigned RAM_AW = 15;
   localparam int unsigned RAM_DW = 16;

   typedef enum logic {
      OWNER_CORE = 1'b0,
      OWNER_VID  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: delays {valid, owner} by RD_LAT cycles so returning
// RAM data can be steered to the requester that issued the read.
module rd_tag_pipe
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage [RD_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < RD_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int unsigned i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between the core and the display reader:
// display has priority with a burst lock, the core is rescued by a wait counter.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned MAX_WAIT  = 4,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [RAM_AW-1:0] core_addr,
   input  logic [RAM_DW-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [RAM_DW-1:0] core_rdata,
   input  logic              vid_req,
   input  logic [RAM_AW-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [RAM_DW-1:0] vid_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [RAM_DW-1:0] ram_wdata,
   input  logic [RAM_DW-1:0] ram_rdata
);

   localparam logic [3:0] MAX_WAIT_L  = 4'(MAX_WAIT);
   localparam logic [7:0] BURST_RELOAD = 8'(BURST_LEN - 1);

   logic [3:0]        wait_cnt;
   logic [3:0]        wait_next;
   logic              starve;
   logic [7:0]        burst_cnt;
   logic [RAM_AW-1:0] hold_addr;
   logic [RAM_DW-1:0] hold_wdata;
   logic              core_win;
   logic              vid_win;
   rd_tag_t           tag_in;
   rd_tag_t           tag_out;

   // An unstarved core only gets the port when display is idle and no burst is locked.
   always_comb begin
      core_win = 1'b0;
      vid_win  = 1'b0;
      if (!reset) begin
         if (starve && core_req)                   core_win = 1'b1;
         else if (vid_req)                         vid_win  = 1'b1;
         else if (core_req && burst_cnt == 8'd0)   core_win = 1'b1;
      end
   end

   assign core_gnt  = core_win;
   assign vid_gnt   = vid_win;
   assign ram_we    = core_win & core_we;
   assign ram_addr  = core_win ? core_addr : (vid_win ? vid_addr : hold_addr);
   assign ram_wdata = core_win ? core_wdata : hold_wdata;

   always_comb begin
      wait_next = '0;
      if (core_req && !core_win)
         wait_next = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
   end

   // starve is registered from the next count so it tracks wait_cnt without extra lag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
         starve   <= 1'b0;
      end else begin
         wait_cnt <= wait_next;
         starve   <= (wait_next >= MAX_WAIT_L);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         burst_cnt <= '0;
      else if (!vid_req)
         burst_cnt <= '0;
      else if (vid_win)
         burst_cnt <= (burst_cnt == 8'd0) ? BURST_RELOAD : burst_cnt - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_addr  <= '0;
         hold_wdata <= '0;
      end else if (core_win) begin
         hold_addr  <= core_addr;
         hold_wdata <= core_wdata;
      end else if (vid_win) begin
         hold_addr  <= vid_addr;
      end
   end

   always_comb begin
      tag_in.valid = (core_win && !core_we) || vid_win;
      tag_in.owner = vid_win ? OWNER_VID : OWNER_CORE;
   end

   rd_tag_pipe #(
      .RD_LAT(RD_LAT)
   ) u_tag_pipe (
      .clk    (clk),
      .reset  (reset),
      .tag_in (tag_in),
      .tag_out(tag_out)
   );

   assign core_rvalid = tag_out.valid && (tag_out.owner == OWNER_CORE) && !reset;
   assign vid_rvalid  = tag_out.valid && (tag_out.owner == OWNER_VID) && !reset;
   assign core_rdata  = ram_rdata;
   assign vid_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two builds (RD_LAT 1 and 2) on shared stimulus,
// checked each cycle against a transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;

   localparam int BURST_LEN = 8;
   localparam int MAX_WAIT  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we, vid_req;
   logic [14:0] core_addr, vid_addr;
   logic [15:0] core_wdata;

   logic        core_gnt1, core_rvalid1, vid_gnt1, vid_rvalid1, ram_we1;
   logic [15:0] core_rdata1, vid_rdata1, ram_wdata1, ram_rdata1;
   logic [14:0] ram_addr1;
   logic        core_gnt2, core_rvalid2, vid_gnt2, vid_rvalid2, ram_we2;
   logic [15:0] core_rdata2, vid_rdata2, ram_wdata2, ram_rdata2;
   logic [14:0] ram_addr2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.BURST_LEN(BURST_LEN), .MAX_WAIT(MAX_WAIT), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt1), .core_rvalid(core_rvalid1), .core_rdata(core_rdata1),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt1),
      .vid_rvalid(vid_rvalid1), .vid_rdata(vid_rdata1),
      .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
   );

   ram_port_arbiter #(.BURST_LEN(BURST_LEN), .MAX_WAIT(MAX_WAIT), .RD_LAT(2)) dut2 (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt2), .core_rvalid(core_rvalid2), .core_rdata(core_rdata2),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt2),
      .vid_rvalid(vid_rvalid2), .vid_rdata(vid_rdata2),
      .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
   );

   // RAM environment driven by dut1's port; the second build sees a 2-cycle read.
   logic [15:0] ram [32768];
   logic [15:0] rd1, rd2;
   always @(posedge clk) begin
      if (ram_we1) ram[ram_addr1] <= ram_wdata1;
      rd1 <= ram[ram_addr1];
      rd2 <= rd1;
   end
   assign ram_rdata1 = rd1;
   assign ram_rdata2 = rd2;

   // Reference model state
   typedef struct {
      int          due;
      bit          vid;
      logic [15:0] data;
   } ret_t;

   logic [15:0] ref_mem [32768];
   ret_t        q1[$];
   ret_t        q2[$];
   int          cyc = 0;
   int          m_wait = 0;
   int          m_burst = 0;
   logic [14:0] m_hold_addr = '0;
   logic [15:0] m_hold_wdata = '0;
   int          core_grants = 0;
   int          vid_grants = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input bit rst, input bit creq, input bit cwe, input logic [14:0] caddr,
                       input logic [15:0] cwd, input bit vreq, input logic [14:0] vaddr);
      bit          starve, exp_core, exp_vid;
      bit          e1c, e1v, e2c, e2v;
      logic [15:0] d1, d2;
      logic [14:0] e_addr;
      logic [15:0] e_wd;
      @(negedge clk);
      reset = rst; core_req = creq; core_we = cwe; core_addr = caddr;
      core_wdata = cwd; vid_req = vreq; vid_addr = vaddr;
      #2;
      starve   = (m_wait >= MAX_WAIT);
      exp_core = !rst && creq && (starve || (!vreq && m_burst == 0));
      exp_vid  = !rst && !exp_core && vreq;
      e_addr   = exp_core ? caddr : (exp_vid ? vaddr : m_hold_addr);
      e_wd     = exp_core ? cwd : m_hold_wdata;

      chk("core_gnt1", 32'(core_gnt1), 32'(exp_core));
      chk("vid_gnt1",  32'(vid_gnt1),  32'(exp_vid));
      chk("ram_we1",   32'(ram_we1),   32'(exp_core && cwe));
      chk("core_gnt2", 32'(core_gnt2), 32'(exp_core));
      chk("vid_gnt2",  32'(vid_gnt2),  32'(exp_vid));
      chk("ram_we2",   32'(ram_we2),   32'(exp_core && cwe));
      if (!rst) begin
         chk("ram_addr1",  32'(ram_addr1),  32'(e_addr));
         chk("ram_wdata1", 32'(ram_wdata1), 32'(e_wd));
         chk("ram_addr2",  32'(ram_addr2),  32'(e_addr));
         chk("ram_wdata2", 32'(ram_wdata2), 32'(e_wd));
      end

      e1c = 0; e1v = 0; e2c = 0; e2v = 0; d1 = '0; d2 = '0;
      if (!rst && q1.size() > 0 && q1[0].due == cyc) begin
         if (q1[0].vid) e1v = 1; else e1c = 1;
         d1 = q1[0].data;
         void'(q1.pop_front());
      end
      if (!rst && q2.size() > 0 && q2[0].due == cyc) begin
         if (q2[0].vid) e2v = 1; else e2c = 1;
         d2 = q2[0].data;
         void'(q2.pop_front());
      end
      chk("core_rvalid1", 32'(core_rvalid1), 32'(e1c));
      chk("vid_rvalid1",  32'(vid_rvalid1),  32'(e1v));
      chk("core_rvalid2", 32'(core_rvalid2), 32'(e2c));
      chk("vid_rvalid2",  32'(vid_rvalid2),  32'(e2v));
      if (e1c) chk("core_rdata1", 32'(core_rdata1), 32'(d1));
      if (e1v) chk("vid_rdata1",  32'(vid_rdata1),  32'(d1));
      if (e2c) chk("core_rdata2", 32'(core_rdata2), 32'(d2));
      if (e2v) chk("vid_rdata2",  32'(vid_rdata2),  32'(d2));

      @(posedge clk);
      if (rst) begin
         m_wait = 0; m_burst = 0; m_hold_addr = '0; m_hold_wdata = '0;
         q1.delete(); q2.delete();
      end else begin
         if (exp_core) begin
            core_grants++;
            m_hold_addr = caddr; m_hold_wdata = cwd;
            if (cwe) ref_mem[caddr] = cwd;
            else begin
               q1.push_back('{cyc + 1, 1'b0, ref_mem[caddr]});
               q2.push_back('{cyc + 2, 1'b0, ref_mem[caddr]});
            end
         end
         if (exp_vid) begin
            vid_grants++;
            m_hold_addr = vaddr;
            q1.push_back('{cyc + 1, 1'b1, ref_mem[vaddr]});
            q2.push_back('{cyc + 2, 1'b1, ref_mem[vaddr]});
         end
         m_wait  = (creq && !exp_core) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
         if (!vreq)        m_burst = 0;
         else if (exp_vid) m_burst = (m_burst == 0) ? BURST_LEN - 1 : m_burst - 1;
      end
      cyc++;
   endtask

   initial begin
      int          cg0, vg0;
      logic [15:0] v;
      reset = 1'b1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      vid_req = 0; vid_addr = '0;
      for (int i = 0; i < 32768; i++) begin
         v = 16'(i * 7) ^ 16'h5A5A;
         ram[i] = v;
         ref_mem[i] = v;
      end

      // reset, then idle: hold registers read back as zero
      step(1, 0, 0, '0, '0, 0, '0);
      step(1, 1, 1, 15'h7FFF, 16'hFFFF, 1, 15'h1234);
      step(0, 0, 0, '0, '0, 0, '0);

      // core write then read back the same word
      step(0, 1, 1, 15'h0005, 16'h1234, 0, '0);
      step(0, 1, 0, 15'h0005, 16'h0000, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      chk("wr_rd_mem", 32'(ram[15'h0005]), 32'h1234);

      // display-only run of 10 reads crossing a burst reload
      for (int i = 0; i < 10; i++) step(0, 0, 0, '0, '0, 1, 15'(16'h0100 + i));
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);

      // both requesting: display first, core forced on once starved
      cg0 = core_grants; vg0 = vid_grants;
      for (int i = 0; i < 5; i++) step(0, 1, 0, 15'(16'h0200 + i), '0, 1, 15'(16'h0300 + i));
      chk("starve_core_grants", 32'(core_grants - cg0), 32'd1);
      chk("starve_vid_grants",  32'(vid_grants - vg0),  32'd4);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 15'(16'h0210 + i), '0, 1, 15'(16'h0310 + i));
      // display drops mid-burst: core must wait out the one-cycle lock release
      step(0, 1, 0, 15'h0400, '0, 0, '0);
      step(0, 1, 0, 15'h0400, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);

      // core read granted, reset the next cycle: return must be dropped
      step(0, 1, 0, 15'h0007, '0, 0, '0);
      step(1, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);

      // core write held against an alternating display reader
      for (int i = 0; i < 8; i++) step(0, 1, 1, 15'h0050, 16'hBEEF, (i % 2) == 0, 15'(16'h0600 + i));
      chk("alt_write_landed", 32'(ram[15'h0050]), 32'hBEEF);
      step(0, 0, 0, '0, '0, 0, '0);

      // back-to-back core reads at 0 and 1
      step(0, 1, 0, 15'h0000, '0, 0, '0);
      step(0, 1, 0, 15'h0001, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);
      step(0, 0, 0, '0, '0, 0, '0);

      // randomized traffic with occasional resets, narrow address window for hits
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              15'($urandom_range(0, 31)), 16'($urandom), ($urandom_range(0, 2) != 0),
              15'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
